// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared constants for the 4x4 keypad scanner: FSM state encoding,
// one-hot column drive patterns and the "no key" code. Also holds a
// small one-hot test and the column rotation used by the scanner.
package keypad_pkg;

  // FSM state encoding (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;

  // Column drive patterns, first column is bit 3
  localparam logic [3:0] COL0 = 4'b1000;
  localparam logic [3:0] COL1 = 4'b0100;
  localparam logic [3:0] COL2 = 4'b0010;
  localparam logic [3:0] COL3 = 4'b0001;

  // Code reported for any combination outside the key matrix
  localparam logic [3:0] NO_KEY = 4'd15;

  // True when exactly one row line is active; zero or several rows
  // at once are both treated as "no key".
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v == 4'b1000) || (v == 4'b0100) ||
           (v == 4'b0010) || (v == 4'b0001);
  endfunction

  // Advance to the next column: 1000 -> 0100 -> 0010 -> 0001 -> 1000
  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// keypad_decode
// Purely combinational key-code table for the 4x4 matrix.
// Ports:
//   col_ref - one-hot column that was driven when the key was seen
//   row_ref - one-hot row that answered on that column
//   code    - 4-bit key code (NO_KEY for anything off the matrix)
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [3:0] col_ref,
  input  logic [3:0] row_ref,
  output logic [3:0] code
);

  // Table lookup; rows listed from bit 3 down to bit 0 in each column
  always_comb begin
    code = NO_KEY;
    case (col_ref)
      COL0: begin
        case (row_ref)
          4'b1000: code = 4'd15;
          4'b0100: code = 4'd1;
          4'b0010: code = 4'd4;
          4'b0001: code = 4'd7;
          default: code = NO_KEY;
        endcase
      end
      COL1: begin
        case (row_ref)
          4'b1000: code = 4'd0;
          4'b0100: code = 4'd2;
          4'b0010: code = 4'd5;
          4'b0001: code = 4'd8;
          default: code = NO_KEY;
        endcase
      end
      COL2: begin
        case (row_ref)
          4'b1000: code = 4'd14;
          4'b0100: code = 4'd3;
          4'b0010: code = 4'd6;
          4'b0001: code = 4'd9;
          default: code = NO_KEY;
        endcase
      end
      COL3: begin
        case (row_ref)
          4'b1000: code = 4'd13;
          4'b0100: code = 4'd10;
          4'b0010: code = 4'd11;
          4'b0001: code = 4'd12;
          default: code = NO_KEY;
        endcase
      end
      default: code = NO_KEY;
    endcase
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 4x4 matrix keypad one column at a time, debounces a single
// pressed key and reports its code once per press.
// Ports:
//   clk       - system clock
//   rst       - asynchronous, active-high reset
//   fil       - keypad row lines (active-high, asynchronous to clk)
//   col       - one-hot column drive, bit 3 is the first column
//   tecla     - code of the last accepted key
//   key_valid - one-cycle pulse in the cycle tecla is updated
//   key_held  - high while the accepted key is still pressed
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] tecla,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DEB_W   = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);
  localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);

  logic [3:0]         sync1_q, fs_q;
  logic [1:0]         state_q, state_d;
  logic [3:0]         col_q, col_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [3:0]         row_ref_q, row_ref_d;
  logic [3:0]         col_ref_q, col_ref_d;
  logic [3:0]         tecla_q, tecla_d;
  logic               key_valid_q, key_valid_d;
  logic               key_held_q, key_held_d;
  logic [3:0]         dec_code;

  keypad_decode u_decode (
    .col_ref (col_ref_q),
    .row_ref (row_ref_q),
    .code    (dec_code)
  );

  // Two-flop synchronizer on the row lines; everything downstream
  // looks only at fs_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      fs_q    <= 4'b0000;
    end else begin
      sync1_q <= fil;
      fs_q    <= sync1_q;
    end
  end

  // Scan / debounce / pressed sequencing. The column is frozen while a
  // candidate key is being debounced and while it stays pressed, so the
  // row lines keep reflecting that one key.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    row_ref_d   = row_ref_q;
    col_ref_d   = col_ref_q;
    tecla_d     = tecla_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (is_one_hot(fs_q)) begin
            row_ref_d = fs_q;
            col_ref_d = col_q;
            deb_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = next_col(col_q);
          end
        end else begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end

      ST_DEBOUNCE: begin
        if (fs_q == row_ref_q) begin
          if (deb_q == DEB_LAST) begin
            tecla_d     = dec_code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            deb_d       = '0;
            state_d     = ST_PRESSED;
          end else begin
            deb_d = deb_q + DEB_ONE;
          end
        end else begin
          // A bounce or a different key: give up and move on
          state_d = ST_SCAN;
          col_d   = next_col(col_q);
          dwell_d = '0;
          deb_d   = '0;
        end
      end

      ST_PRESSED: begin
        // Release needs DEBOUNCE_CNT consecutive all-zero samples; any
        // activity, even on another row, restarts the count.
        if (fs_q == 4'b0000) begin
          if (deb_q == DEB_LAST) begin
            key_held_d = 1'b0;
            state_d    = ST_SCAN;
            col_d      = next_col(col_q);
            dwell_d    = '0;
            deb_d      = '0;
          end else begin
            deb_d = deb_q + DEB_ONE;
          end
        end else begin
          deb_d = '0;
        end
      end

      default: begin
        state_d    = ST_SCAN;
        col_d      = COL0;
        dwell_d    = '0;
        deb_d      = '0;
        key_held_d = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_q       <= COL0;
      dwell_q     <= '0;
      deb_q       <= '0;
      row_ref_q   <= 4'b0000;
      col_ref_q   <= 4'b0000;
      tecla_q     <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      row_ref_q   <= row_ref_d;
      col_ref_q   <= col_ref_d;
      tecla_q     <= tecla_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign tecla     = tecla_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Self-checking bench for keypad_scan_ctrl with SCAN_DIV=4 and
// DEBOUNCE_CNT=8. A small keypad model answers on the row lines when the
// pressed key's column is driven. Expected codes are queued when a press
// is made and popped by a monitor on every key_valid pulse.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] fil;
  logic [3:0] col;
  logic [3:0] tecla;
  logic       key_valid;
  logic       key_held;

  // Keypad model state
  logic       press_en;
  logic [3:0] press_col;
  logic [3:0] press_row;

  int         checks;
  int         errors;
  int         pulse_count;
  logic [3:0] exp_q[$];

  keypad_scan_ctrl #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fil       (fil),
    .col       (col),
    .tecla     (tecla),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: the pressed switch connects its column to its row
  always_comb begin
    fil = 4'b0000;
    if (press_en && (col == press_col))
      fil = press_row;
  end

  // Scoreboard monitor: each pulse must match the oldest queued code,
  // and the column drive must be one-hot on every cycle.
  always @(negedge clk) begin
    checks++;
    if (!$onehot(col)) begin
      errors++;
      $display("[TB] FAIL col_onehot col=%b", col);
    end
    if (!rst && key_valid) begin
      checks++;
      pulse_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse tecla=%0d expected none", tecla);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (tecla !== e) begin
          errors++;
          $display("[TB] FAIL pulse_code tecla=%0d expected %0d", tecla, e);
        end
      end
    end
  end

  // Waits (bounded) for the next key_valid pulse seen by the monitor
  task automatic wait_pulse(input int budget, output bit ok);
    int start;
    start = pulse_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (pulse_count != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Waits (bounded) for key_held to drop
  task automatic wait_release(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (key_held === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col;
    rst = 1'b1;
    press_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (col !== 4'b1000 || tecla !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values col=%b tecla=%0d kv=%b kh=%b expected 1000/0/0/0",
               col, tecla, key_valid, key_held);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      exp_col = 4'b1000 >> ((i / 4) % 4);
      checks++;
      if (col !== exp_col) begin
        errors++;
        $display("[TB] FAIL scan_seq cycle=%0d col=%b expected %b", i, col, exp_col);
      end
    end
    checks++;
    if (tecla !== 4'd0 || pulse_count != 0) begin
      errors++;
      $display("[TB] FAIL idle_no_key tecla=%0d pulses=%0d expected 0/0", tecla, pulse_count);
    end
  endtask

  task automatic test_press_release;
    bit ok;
    int start;
    start = pulse_count;
    press_col = 4'b0100;
    press_row = 4'b0010;
    press_en  = 1'b1;
    exp_q.push_back(4'd5);
    wait_pulse(100, ok);
    checks++;
    if (!ok || key_held !== 1'b1 || tecla !== 4'd5) begin
      errors++;
      $display("[TB] FAIL press_5 seen=%0b kh=%b tecla=%0d expected 1/1/5", ok, key_held, tecla);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (pulse_count - start != 1 || key_held !== 1'b1 || col !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL hold_no_repeat pulses=%0d kh=%b col=%b expected 1/1/0100",
               pulse_count - start, key_held, col);
    end
    press_en = 1'b0;
    wait_release(50, ok);
    checks++;
    if (!ok || col !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL release_5 seen=%0b col=%b expected 1/0010", ok, col);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (col !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL scan_resume col=%b expected 0001", col);
    end
  endtask

  task automatic test_bounce;
    bit ok;
    int start;
    start = pulse_count;
    press_col = 4'b0001;
    press_row = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) press_en = ~press_en;
      @(negedge clk);
    end
    checks++;
    if (pulse_count != start) begin
      errors++;
      $display("[TB] FAIL bounce_no_pulse pulses=%0d expected 0", pulse_count - start);
    end
    press_en = 1'b1;
    exp_q.push_back(4'd10);
    wait_pulse(100, ok);
    checks++;
    if (!ok || tecla !== 4'd10) begin
      errors++;
      $display("[TB] FAIL bounce_press seen=%0b tecla=%0d expected 1/10", ok, tecla);
    end
    press_en = 1'b0;
    wait_release(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL bounce_release key_held=%b expected 0", key_held);
    end
  endtask

  task automatic test_multi_key;
    int start;
    int col_changes;
    logic [3:0] last_col;
    start = pulse_count;
    press_col = 4'b1000;
    press_row = 4'b1001;
    press_en  = 1'b1;
    col_changes = 0;
    last_col = col;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (col !== last_col) col_changes++;
      last_col = col;
    end
    checks++;
    if (pulse_count != start || key_held !== 1'b0 || col_changes < 8) begin
      errors++;
      $display("[TB] FAIL multi_key pulses=%0d kh=%b col_changes=%0d expected 0/0/>=8",
               pulse_count - start, key_held, col_changes);
    end
    press_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_sweep;
    bit ok;
    logic [3:0] codes [16];
    codes = '{4'd15, 4'd1, 4'd4, 4'd7, 4'd0, 4'd2, 4'd5, 4'd8,
              4'd14, 4'd3, 4'd6, 4'd9, 4'd13, 4'd10, 4'd11, 4'd12};
    for (int k = 0; k < 16; k++) begin
      press_col = 4'b1000 >> (k / 4);
      press_row = 4'b1000 >> (k % 4);
      press_en  = 1'b1;
      exp_q.push_back(codes[k]);
      wait_pulse(100, ok);
      checks++;
      if (!ok || key_held !== 1'b1 || tecla !== codes[k]) begin
        errors++;
        $display("[TB] FAIL sweep_key%0d seen=%0b kh=%b tecla=%0d expected 1/1/%0d",
                 k, ok, key_held, tecla, codes[k]);
      end
      press_en = 1'b0;
      wait_release(50, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL sweep_release%0d key_held=%b expected 0", k, key_held);
      end
    end
  endtask

  task automatic test_reset_mid_press;
    bit ok;
    press_col = 4'b0010;
    press_row = 4'b1000;
    press_en  = 1'b1;
    exp_q.push_back(4'd14);
    wait_pulse(100, ok);
    checks++;
    if (!ok || key_held !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_press seen=%0b kh=%b expected 1/1", ok, key_held);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (col !== 4'b1000 || key_held !== 1'b0 || key_valid !== 1'b0 || tecla !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_press col=%b kh=%b kv=%b tecla=%0d expected 1000/0/0/0",
               col, key_held, key_valid, tecla);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'd14);
    wait_pulse(100, ok);
    checks++;
    if (!ok || tecla !== 4'd14 || key_held !== 1'b1) begin
      errors++;
      $display("[TB] FAIL re_report seen=%0b tecla=%0d kh=%b expected 1/14/1", ok, tecla, key_held);
    end
    press_en = 1'b0;
    wait_release(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL final_release key_held=%b expected 0", key_held);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    pulse_count = 0;
    rst         = 1'b1;
    press_en    = 1'b0;
    press_col   = 4'b1000;
    press_row   = 4'b0000;

    test_reset();
    test_press_release();
    test_bounce();
    test_multi_key();
    test_sweep();
    test_reset_mid_press();

    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_pulses outstanding=%0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
